// File: rtl/uart_tx_cfg.sv
// UART transmitter with per-frame configuration.
// Frames are START, N data bits (LSB first), optional parity, then STOP. Each bit period is
// OS ticks of the oversampling strobe. The configuration is latched together with the
// payload, so changes during a frame only apply to the next one.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   s_tick       single-cycle oversampling strobe from the baud generator
//   din          payload, LSB transmitted first
//   din_valid    payload offered
//   din_ready    payload accepted this cycle when din_valid is also high (IDLE only)
//   cfg_nbits    data bits per frame; values outside 5..DBIT select DBIT
//   cfg_parity   00 none, 01 even, 10 odd, 11 none
//   cfg_stop     00 1 bit, 01 1.5 bits, 10 2 bits, 11 1 bit
//   tx           registered serial line, idle high
//   tx_done_tick one-cycle pulse on the final STOP tick
//   busy         high whenever a frame is in progress
module uart_tx_cfg #(
   parameter int unsigned DBIT = 8,
   parameter int unsigned OS   = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            s_tick,
   input  logic [DBIT-1:0] din,
   input  logic            din_valid,
   output logic            din_ready,
   input  logic [3:0]      cfg_nbits,
   input  logic [1:0]      cfg_parity,
   input  logic [1:0]      cfg_stop,
   output logic            tx,
   output logic            tx_done_tick,
   output logic            busy
);

   // Tick counter must reach 2*OS-1 for a two-bit stop.
   localparam int unsigned TW = $clog2(2 * OS);
   localparam int unsigned BW = $clog2(DBIT);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
      StParity = 3'd3,
      StStop   = 3'd4
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   tick_q, tick_d;
   logic [BW-1:0]   bit_q, bit_d;
   logic [BW-1:0]   last_q, last_d;        // index of the final data bit (N-1)
   logic [DBIT-1:0] shift_q, shift_d;
   logic            par_q, par_d;          // parity bit value, already inverted for odd
   logic            par_en_q, par_en_d;
   logic [TW-1:0]   stop_last_q, stop_last_d;
   logic            tx_q, tx_d;

   logic            nb_ok;
   logic [3:0]      n_eff;
   logic [DBIT-1:0] mask;
   logic            bit_end;

   assign din_ready = (state_q == StIdle);
   assign busy      = (state_q != StIdle);
   assign tx        = tx_q;
   assign bit_end   = (tick_q == TW'(OS - 1));

   // Effective bit count and payload mask, used only at acceptance.
   always_comb begin
      nb_ok = (cfg_nbits >= 4'd5) && (32'(cfg_nbits) <= DBIT);
      n_eff = nb_ok ? cfg_nbits : 4'(DBIT);
      mask  = '0;
      for (int i = 0; i < int'(DBIT); i++) begin
         mask[i] = (i < int'(n_eff));
      end
   end

   always_comb begin
      state_d      = state_q;
      tick_d       = tick_q;
      bit_d        = bit_q;
      last_d       = last_q;
      shift_d      = shift_q;
      par_d        = par_q;
      par_en_d     = par_en_q;
      stop_last_d  = stop_last_q;
      tx_d         = tx_q;
      tx_done_tick = 1'b0;

      case (state_q)
         StIdle: begin
            tx_d = 1'b1;
            // s_tick is ignored here, so a tick coincident with acceptance is not counted.
            if (din_valid) begin
               state_d  = StStart;
               tx_d     = 1'b0;
               tick_d   = '0;
               bit_d    = '0;
               last_d   = BW'(n_eff - 4'd1);
               shift_d  = din & mask;
               par_en_d = cfg_parity[0] ^ cfg_parity[1];
               par_d    = (^(din & mask)) ^ cfg_parity[1];
               case (cfg_stop)
                  2'b01:   stop_last_d = TW'((3 * OS) / 2 - 1);
                  2'b10:   stop_last_d = TW'(2 * OS - 1);
                  default: stop_last_d = TW'(OS - 1);
               endcase
            end
         end
         StStart: begin
            if (s_tick) begin
               if (bit_end) begin
                  state_d = StData;
                  tick_d  = '0;
                  tx_d    = shift_q[0];
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         StData: begin
            if (s_tick) begin
               if (bit_end) begin
                  tick_d  = '0;
                  shift_d = shift_q >> 1;
                  if (bit_q == last_q) begin
                     bit_d = '0;
                     if (par_en_q) begin
                        state_d = StParity;
                        tx_d    = par_q;
                     end else begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                     end
                  end else begin
                     bit_d = bit_q + BW'(1);
                     tx_d  = shift_q[1];
                  end
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         StParity: begin
            if (s_tick) begin
               if (bit_end) begin
                  state_d = StStop;
                  tick_d  = '0;
                  tx_d    = 1'b1;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         StStop: begin
            if (s_tick) begin
               if (tick_q == stop_last_q) begin
                  state_d      = StIdle;
                  tick_d       = '0;
                  tx_done_tick = 1'b1;
               end else begin
                  tick_d = tick_q + TW'(1);
               end
            end
         end
         default: begin
            state_d = StIdle;
            tick_d  = '0;
            bit_d   = '0;
            tx_d    = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= StIdle;
         tick_q      <= '0;
         bit_q       <= '0;
         last_q      <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         par_en_q    <= 1'b0;
         stop_last_q <= '0;
         tx_q        <= 1'b1;
      end else begin
         state_q     <= state_d;
         tick_q      <= tick_d;
         bit_q       <= bit_d;
         last_q      <= last_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         par_en_q    <= par_en_d;
         stop_last_q <= stop_last_d;
         tx_q        <= tx_d;
      end
   end

endmodule
